mul6_shift_add: RTL and testbench
=================================

# mul6_shift_add

Sequential 6x6 unsigned multiplier that drives the team's combinational 6-bit ripple-carry adder, with one add per cycle. The block owns the operand, accumulator and counter registers and the control FSM. It presents the adder inputs on dedicated ports and captures the adder's sum and carry-out in the same cycle. Operands arrive on a valid/ready request channel and 12-bit products leave on a valid/ready response channel, so the block sits between operand sources and the arithmetic datapath.

## Interface
- No parameters; the width is fixed at 6 bits to match the adder.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start_valid  in  1  the op_a/op_b request is valid.
- start_ready  out  1  the block can accept a request.
- op_a  in  6  multiplicand, unsigned.
- op_b  in  6  multiplier, unsigned.
- add_a  out  6  adder operand A.
- add_b  out  6  adder operand B.
- add_cin  out  1  adder carry-in, tied to 0.
- add_sum  in  6  adder sum (combinational response to add_a/add_b/add_cin).
- add_cout  in  1  adder carry-out.
- prod  out  12  product op_a*op_b, registered.
- prod_valid  out  1  prod is valid.
- prod_ready  in  1  the consumer accepts prod.
- busy  out  1  high in RUN or DONE.

## Operation
- Internal registers:
  - m[5:0]: multiplicand.
  - acc[5:0]: upper partial product.
  - q[5:0]: multiplier, shifting to become the lower product.
  - cnt[2:0]: step counter.
  - state: one of IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - Accept on start_valid && start_ready: m <= op_a, q <= op_b, acc <= 0, cnt <= 0, go to RUN.
  - op_a/op_b are ignored unless accepted.
- RUN:
  - Adder drive: add_a = acc, add_b = q[0] ? m : 6'h00, add_cin = 0.
  - Each edge: acc <= {add_cout, add_sum[5:1]}, q <= {add_sum[0], q[5:1]}, cnt <= cnt + 1.
  - When cnt == 5 on the edge: prod <= {add_cout, add_sum, q[5:1]}, prod_valid <= 1, go to DONE.
- DONE:
  - prod and prod_valid hold stable until prod_valid && prod_ready.
  - On that handshake: prod_valid <= 0, go to IDLE. prod keeps its last value.
- Outside RUN: add_a = 0, add_b = 0, add_cin = 0.
- start_ready is 0 in RUN and DONE. A start_valid asserted then is not accepted, and the upstream must hold its request.
- Arithmetic: unsigned only; the 12-bit product cannot overflow (maximum 63*63 = 0xF81). add_cout is the 7th bit of each partial sum and must be captured, never dropped.
- State encoding and cnt are internal. Only the ports are verified.

## Timing
- Reset (rst_n = 0 at an edge):
  - After the edge: state = IDLE; m, acc, q, cnt = 0; prod = 12'h000; prod_valid = 0; busy = 0.
  - start_ready = (state == IDLE) && rst_n, so it is 0 while rst_n is low.
- Reset mid-operation (RUN or DONE): abort at that edge with the reset values above. No prod_valid is emitted for the aborted request.
- Latency:
  - Request accepted at edge E.
  - RUN steps occur at edges E+1 … E+6.
  - prod_valid is high from edge E+6.
- Throughput: at most one product per 8 cycles when prod_ready is held high. The result handshake happens at E+7 and IDLE resumes, so the next accept is at E+8 at the earliest.
- prod_ready held low: DONE persists indefinitely with prod constant.
- prod_ready high is ignored outside DONE.
- busy = (state != IDLE), registered state only.

## Test plan
- Reset, then check idle outputs: prod = 0x000, prod_valid = 0, start_ready = 1, busy = 0, add_a = add_b = 0.
- op_a = 0x3F, op_b = 0x3F, prod_ready = 1 -> prod = 0xF81, prod_valid rises exactly 6 edges after the accept, start_ready is 0 for those edges.
- op_a = 0x15, op_b = 0x2A -> prod = 0x372. add_b is 0x00, 0x15, 0x00, 0x15, 0x00, 0x15 over the 6 RUN cycles, and add_cin = 0 throughout.
- op_a = 0x2A, op_b = 0x00 -> prod = 0x000. Follow with op_a = 0x01, op_b = 0x3F -> prod = 0x03F.
- Hold prod_ready = 0 for 10 cycles after prod_valid, with start_valid = 1 and new operands -> prod stable, no new accept. Raise prod_ready -> handshake, IDLE, then accept of the new request.
- Assert rst_n = 0 at the 3rd RUN cycle of 0x3F*0x3F -> next cycle shows the reset values. After release, 0x07*0x09 -> 0x03F.

Source files
------------

// File: rtl/mul6_shift_add.sv
// Sequential 6x6 unsigned shift-add multiplier driving an external 6-bit adder.
// One add per RUN cycle; the 12-bit product is returned on a valid/ready channel.
module mul6_shift_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [5:0]  op_a,
  input  logic [5:0]  op_b,
  output logic [5:0]  add_a,
  output logic [5:0]  add_b,
  output logic        add_cin,
  input  logic [5:0]  add_sum,
  input  logic        add_cout,
  output logic [11:0] prod,
  output logic        prod_valid,
  input  logic        prod_ready,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a producer holds valid and its payload stable until then.

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  m_q, m_d;
  logic [5:0]  acc_q, acc_d;
  logic [5:0]  q_q, q_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] prod_q, prod_d;
  logic        prod_valid_q, prod_valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      m_q          <= 6'h00;
      acc_q        <= 6'h00;
      q_q          <= 6'h00;
      cnt_q        <= 3'd0;
      prod_q       <= 12'h000;
      prod_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      acc_q        <= acc_d;
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    acc_d        = acc_q;
    q_d          = q_q;
    cnt_d        = cnt_q;
    prod_d       = prod_q;
    prod_valid_d = prod_valid_q;
    add_a        = 6'h00;
    add_b        = 6'h00;
    add_cin      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          m_d     = op_a;
          q_d     = op_b;
          acc_d   = 6'h00;
          cnt_d   = 3'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        add_a = acc_q;
        add_b = q_q[0] ? m_q : 6'h00;
        // The carry-out becomes the top bit of the shifted accumulator.
        acc_d = {add_cout, add_sum[5:1]};
        q_d   = {add_sum[0], q_q[5:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          prod_d       = {add_cout, add_sum, q_q[5:1]};
          prod_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (prod_ready) begin
          prod_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start_ready = (state_q == S_IDLE) && rst_n;
  assign busy        = (state_q != S_IDLE);
  assign prod        = prod_q;
  assign prod_valid  = prod_valid_q;

endmodule

// File: tb/tb_mul6_shift_add.sv
// Bench for mul6_shift_add: models the external adder, scores products against
// plain multiplication and checks per-step adder drive and handshake timing.
module tb_mul6_shift_add;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [5:0]  op_a;
  logic [5:0]  op_b;
  logic [5:0]  add_a;
  logic [5:0]  add_b;
  logic        add_cin;
  logic [5:0]  add_sum;
  logic        add_cout;
  logic [11:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  logic [5:0]  nxt_a, nxt_b;

  mul6_shift_add dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .busy(busy)
  );

  // External ripple-carry adder seen by the block.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {6'd0, add_cin};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: sim time %0t exceeded, required finish earlier", $time);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%03h expected 0x%03h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // One request/response; hold = cycles prod_ready stays low after prod_valid,
  // keep_req = present nxt_a/nxt_b as a pending request during and after DONE.
  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input int hold, input bit keep_req);
    int t;
    int unsigned exp_acc;
    logic [11:0] exp_p;
    op_a = a;
    op_b = b;
    start_valid = 1'b1;
    t = 0;
    while (!start_ready && t < 20) begin
      tick();
      t++;
    end
    check_eq("accept_ready", {11'd0, start_ready}, 12'd1);
    if (!start_ready) begin
      start_valid = 1'b0;
      return;
    end
    exp_q.push_back(12'(a) * 12'(b));
    tick();
    for (int k = 1; k <= 6; k++) begin
      start_valid = 1'($urandom_range(0, 1));
      op_a        = 6'($urandom_range(0, 63));
      op_b        = 6'($urandom_range(0, 63));
      prod_ready  = 1'($urandom_range(0, 1));
      // Accumulator before step k: upper part of a * (low k-1 bits of b).
      exp_acc = (int'(a) * (int'(b) & ((1 << (k - 1)) - 1))) >> (k - 1);
      check_eq("run_start_ready", {11'd0, start_ready}, 12'd0);
      check_eq("run_busy", {11'd0, busy}, 12'd1);
      check_eq("run_prod_valid", {11'd0, prod_valid}, 12'd0);
      check_eq("run_add_cin", {11'd0, add_cin}, 12'd0);
      check_eq("run_add_b", {6'd0, add_b}, b[k-1] ? {6'd0, a} : 12'd0);
      check_eq("run_add_a", {6'd0, add_a}, 12'(exp_acc));
      tick();
    end
    if (keep_req) begin
      start_valid = 1'b1;
      op_a = nxt_a;
      op_b = nxt_b;
    end else begin
      start_valid = 1'b0;
    end
    prod_ready = (hold == 0);
    exp_p = exp_q.pop_front();
    check_eq("done_prod_valid", {11'd0, prod_valid}, 12'd1);
    check_eq("done_prod", prod, exp_p);
    check_eq("done_start_ready", {11'd0, start_ready}, 12'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("hold_prod_valid", {11'd0, prod_valid}, 12'd1);
      check_eq("hold_prod", prod, exp_p);
      check_eq("hold_no_accept", {11'd0, busy}, 12'd1);
    end
    prod_ready = 1'b1;
    tick();
    check_eq("hs_prod_valid", {11'd0, prod_valid}, 12'd0);
    check_eq("hs_busy", {11'd0, busy}, 12'd0);
    check_eq("hs_start_ready", {11'd0, start_ready}, 12'd1);
    check_eq("hs_prod_kept", prod, exp_p);
    prod_ready = 1'($urandom_range(0, 1));
    if (!keep_req) start_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_prod"}, prod, 12'h000);
    check_eq({tag, "_prod_valid"}, {11'd0, prod_valid}, 12'd0);
    check_eq({tag, "_busy"}, {11'd0, busy}, 12'd0);
    check_eq({tag, "_add_a"}, {6'd0, add_a}, 12'd0);
    check_eq({tag, "_add_b"}, {6'd0, add_b}, 12'd0);
    check_eq({tag, "_add_cin"}, {11'd0, add_cin}, 12'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start_valid = 1'b0;
    op_a = 6'h00;
    op_b = 6'h00;
    prod_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_start_ready_low", {11'd0, start_ready}, 12'd0);
    check_reset_values("rst");
    rst_n = 1'b1;
    #1;
    check_eq("idle_start_ready", {11'd0, start_ready}, 12'd1);

    run_op(6'h3F, 6'h3F, 0, 1'b0);
    run_op(6'h15, 6'h2A, 0, 1'b0);
    run_op(6'h2A, 6'h00, 0, 1'b0);
    run_op(6'h01, 6'h3F, 0, 1'b0);

    // Back-pressure with a new request waiting.
    nxt_a = 6'h2B;
    nxt_b = 6'h11;
    run_op(6'h09, 6'h0B, 10, 1'b1);
    run_op(nxt_a, nxt_b, 0, 1'b0);

    // Reset in the third RUN cycle aborts the request.
    op_a = 6'h3F;
    op_b = 6'h3F;
    start_valid = 1'b1;
    check_eq("abort_accept_ready", {11'd0, start_ready}, 12'd1);
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    check_eq("abort_busy_before", {11'd0, busy}, 12'd1);
    rst_n = 1'b0;
    tick();
    check_eq("abort_start_ready_low", {11'd0, start_ready}, 12'd0);
    check_reset_values("abort");
    rst_n = 1'b1;
    #1;
    check_eq("abort_start_ready", {11'd0, start_ready}, 12'd1);
    prod_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("abort_no_result", {11'd0, prod_valid}, 12'd0);
    end
    run_op(6'h07, 6'h09, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      run_op(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), $urandom_range(0, 3), 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    check_eq("scoreboard_empty", 12'(exp_q.size()), 12'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
